// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per clock; sign fix-up and writeback in a final cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_mag_a;
  logic [W-1:0]    r_mag_b;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_quo;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_acc_nxt;
  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_quo_nxt;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(W - 1)) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand magnitudes; op[0]=0 selects the signed variants
  always_comb begin
    w_a_neg = ~op[0] & a[W-1];
    w_b_neg = ~op[0] & b[W-1];
    w_mag_a = w_a_neg ? ({W{1'b0}} - a) : a;
    w_mag_b = w_b_neg ? ({W{1'b0}} - b) : b;
  end

  // Datapath step: multiplier sits in the low half of the accumulator and shifts out
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag_a} : {(W+1){1'b0}});
    w_acc_nxt = {w_mul_sum, r_acc[W-1:1]};
    w_rem_sh  = {r_rem, r_quo[W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
    w_rem_nxt = w_ge ? W'(w_rem_sh - {1'b0, r_mag_b}) : w_rem_sh[W-1:0];
    w_quo_nxt = {r_quo[W-2:0], w_ge};
  end

  // Sign correction applied in the FIX cycle
  always_comb begin
    w_prod_fix = r_neg_res ? ({(2*W){1'b0}} - r_acc) : r_acc;
    w_quo_fix  = r_neg_res ? ({W{1'b0}} - r_quo) : r_quo;
    w_rem_fix  = r_neg_rem ? ({W{1'b0}} - r_rem) : r_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a       <= '0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      done    <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_a       <= a;
            r_mag_a   <= w_mag_a;
            r_mag_b   <= w_mag_b;
            r_acc     <= {{W{1'b0}}, w_mag_b};
            r_rem     <= '0;
            r_quo     <= w_mag_a;
          end else begin
            if (hi_we) hi <= write_data;
            if (lo_we) lo <= write_data;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_is_div) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
          end else begin
            r_acc <= w_acc_nxt;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            // Divide by zero: no trap, report dividend and all-ones quotient
            if (r_mag_b == '0) begin
              hi <= r_a;
              lo <= '1;
            end else begin
              hi <= w_rem_fix;
              lo <= w_quo_fix;
            end
          end else begin
            hi <= w_prod_fix[2*W-1:W];
            lo <= w_prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, signed/unsigned results,
// boundary cases, ignored inputs while busy, reset abort and MTHI/MTLO priority.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic saw_done;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive start for one edge (E0); returns at the falling edge after E0
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  // Called right after launch: checks busy window, result at E33 and done falling at E34
  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el);
    check({tag, "_busy_e0"}, 64'(busy), 64'(1));
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 32) begin
        check({tag, "_busy_e32"}, 64'(busy), 64'(1));
        check({tag, "_nodone_e32"}, 64'(done), 64'(0));
        check({tag, "_hold_e32"}, {hi, lo}, {m_hi, m_lo});
      end
    end
    tick();
    check({tag, "_done_e33"}, 64'(done), 64'(1));
    check({tag, "_idle_e33"}, 64'(busy), 64'(0));
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
    m_hi = eh;
    m_lo = el;
    tick();
    check({tag, "_done_e34"}, 64'(done), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    launch(o, x, y);
    finish_op(tag, eh, el);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_hi       = '0;
    m_lo       = '0;
    reset      = 1'b1;
    start      = 1'b0;
    op         = '0;
    a          = '0;
    b          = '0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    reset = 1'b0;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_wrap",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", OP_DIVU,  32'h64,        32'd0,         32'h64,        32'hFFFF_FFFF);
    run_op("div_zero",  OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Disturbances while busy: operand change, second start, MTHI, start on the FIX edge
    launch(OP_MULTU, 32'd6, 32'd7);
    for (int e = 1; e <= 33; e++) begin
      if (e == 2) a = 32'd99;
      start      = (e == 5) || (e == 33);
      op         = OP_DIV;
      b          = 32'd3;
      hi_we      = (e == 10);
      write_data = 32'h0000_DEAD;
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      if (e == 10) check("mthi_busy", 64'(hi), 64'(m_hi));
      if (e == 33) begin
        check("dist_done", 64'(done), 64'(1));
        check("dist_hilo", {hi, lo}, {32'd0, 32'd42});
        check("start_fix_ignored", 64'(busy), 64'(0));
      end
    end
    m_hi = 32'd0;
    m_lo = 32'd42;
    tick();
    check("dist_idle_e34", 64'(busy), 64'(0));

    // Reset mid-operation
    launch(OP_DIVU, 32'd100, 32'd7);
    for (int e = 1; e <= 10; e++) begin
      reset = (e == 10);
      tick();
      reset = 1'b0;
    end
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hilo", {hi, lo}, 64'(0));
    m_hi = '0;
    m_lo = '0;
    saw_done = 1'b0;
    for (int e = 0; e < 30; e++) begin
      tick();
      saw_done = saw_done | done;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));

    lo_we      = 1'b1;
    write_data = 32'h0000_1234;
    tick();
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'd0, 32'h0000_1234});

    hi_we      = 1'b1;
    lo_we      = 1'b1;
    write_data = 32'h0000_5555;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h0000_5555, 32'h0000_5555});
    m_hi = 32'h0000_5555;
    m_lo = 32'h0000_5555;

    // start wins over a simultaneous MTHI
    hi_we      = 1'b1;
    write_data = 32'h0000_BEEF;
    launch(OP_MULTU, 32'd3, 32'd4);
    hi_we = 1'b0;
    check("start_over_mthi", 64'(hi), 64'(32'h0000_5555));
    finish_op("mul_after_mthi", 32'd0, 32'd12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
